// File: rtl/pipe_stall_flush_ctrl.sv
// rtl/pipe_stall_flush_ctrl.sv - prefix stall vector, redirect flush FSM with refill masking and stuck-stall watchdog
// Optional performance counters enabled by defining PIPE_CTRL_PERF_EN.
module pipe_stall_flush_ctrl #(
    parameter int STAGES     = 6,
    parameter int PC_W       = 32,
    parameter int REFILL_CYC = 2,
    parameter int CNT_W      = 8,
    parameter int TIMEOUT    = 200
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [STAGES-1:0] stallreq,
    input  logic              excp_req,
    input  logic [PC_W-1:0]   excp_pc,
    input  logic              eret_req,
    input  logic [PC_W-1:0]   eret_pc,
    output logic [STAGES-1:0] stall,
    output logic              flush,
    output logic [PC_W-1:0]   new_pc,
    output logic              stall_timeout,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [31:0]       stall_total,
    output logic [15:0]       flush_total
);

    localparam int RW = $clog2(REFILL_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_TO  = CNT_W'(TIMEOUT);
    localparam logic [RW-1:0]    RCNT_LD = RW'(REFILL_CYC);
    localparam logic [RW-1:0]    RCNT_1  = RW'(1);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        FLUSH  = 2'd1,
        REFILL = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [RW-1:0]     rcnt, rcnt_nxt;
    logic              pend, pend_nxt;
    logic [PC_W-1:0]   pend_pc, pend_pc_nxt;
    logic [PC_W-1:0]   new_pc_nxt;
    logic              req;
    logic [PC_W-1:0]   req_pc;
    logic [STAGES-1:0] prefix;
    logic              acc;
    logic [CNT_W-1:0]  cnt_nxt;

    // Exception beats ERET when both arrive together; the ERET is simply lost.
    assign req    = excp_req | eret_req;
    assign req_pc = excp_req ? excp_pc : eret_pc;

    always_comb begin
        acc    = 1'b0;
        prefix = '0;
        for (int i = STAGES - 1; i >= 0; i--) begin
            acc       = acc | stallreq[i];
            prefix[i] = acc;
        end
        stall = (state == FLUSH) ? '0 : prefix;
    end

    always_comb begin
        state_nxt   = state;
        rcnt_nxt    = rcnt;
        pend_nxt    = pend;
        pend_pc_nxt = pend_pc;
        new_pc_nxt  = new_pc;
        case (state)
            RUN: begin
                if (pend) begin
                    new_pc_nxt = pend_pc;
                    pend_nxt   = 1'b0;
                    state_nxt  = FLUSH;
                end else if (req) begin
                    new_pc_nxt = req_pc;
                    state_nxt  = FLUSH;
                end
            end
            FLUSH: begin
                state_nxt = REFILL;
                rcnt_nxt  = RCNT_LD;
                if (req && !pend) begin
                    pend_nxt    = 1'b1;
                    pend_pc_nxt = req_pc;
                end
            end
            REFILL: begin
                if (req && !pend) begin
                    pend_nxt    = 1'b1;
                    pend_pc_nxt = req_pc;
                end
                // Last refill cycle: an older pending redirect outranks one arriving now.
                if (rcnt == RCNT_1) begin
                    if (pend) begin
                        new_pc_nxt = pend_pc;
                        pend_nxt   = 1'b0;
                        state_nxt  = FLUSH;
                    end else if (req) begin
                        new_pc_nxt = req_pc;
                        pend_nxt   = 1'b0;
                        state_nxt  = FLUSH;
                    end else begin
                        state_nxt = RUN;
                    end
                end else begin
                    rcnt_nxt = rcnt - RCNT_1;
                end
            end
            default: begin
                state_nxt = RUN;
                pend_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= RUN;
            rcnt    <= '0;
            pend    <= 1'b0;
            pend_pc <= '0;
            new_pc  <= '0;
            flush   <= 1'b0;
        end else begin
            state   <= state_nxt;
            rcnt    <= rcnt_nxt;
            pend    <= pend_nxt;
            pend_pc <= pend_pc_nxt;
            new_pc  <= new_pc_nxt;
            flush   <= (state_nxt == FLUSH);
        end
    end

    always_comb begin
        if ((stall == '0) || flush)
            cnt_nxt = '0;
        else if (stall_cnt == CNT_MAX)
            cnt_nxt = stall_cnt;
        else
            cnt_nxt = stall_cnt + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt     <= '0;
            stall_timeout <= 1'b0;
        end else begin
            stall_cnt     <= cnt_nxt;
            stall_timeout <= stall_timeout | (cnt_nxt == CNT_TO);
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] stall_total_q;
    logic [15:0] flush_total_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_total_q <= '0;
            flush_total_q <= '0;
        end else begin
            if (stall[0])
                stall_total_q <= stall_total_q + 32'd1;
            if (flush && (flush_total_q != 16'hFFFF))
                flush_total_q <= flush_total_q + 16'd1;
        end
    end

    assign stall_total = stall_total_q;
    assign flush_total = flush_total_q;
`else
    assign stall_total = 32'd0;
    assign flush_total = 16'd0;
`endif

endmodule

// File: tb/tb_pipe_stall_flush_ctrl.sv
// tb/tb_pipe_stall_flush_ctrl.sv - directed self-checking bench for pipe_stall_flush_ctrl
module tb_pipe_stall_flush_ctrl;

    logic        clk;
    logic        rst;
    logic [5:0]  stallreq;
    logic        excp_req;
    logic [31:0] excp_pc;
    logic        eret_req;
    logic [31:0] eret_pc;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        stall_timeout;
    logic [7:0]  stall_cnt;
    logic [31:0] stall_total;
    logic [15:0] flush_total;

    int total = 0;
    int bad   = 0;

    pipe_stall_flush_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .stallreq     (stallreq),
        .excp_req     (excp_req),
        .excp_pc      (excp_pc),
        .eret_req     (eret_req),
        .eret_pc      (eret_pc),
        .stall        (stall),
        .flush        (flush),
        .new_pc       (new_pc),
        .stall_timeout(stall_timeout),
        .stall_cnt    (stall_cnt),
        .stall_total  (stall_total),
        .flush_total  (flush_total)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst      = 1'b1;
        stallreq = '0;
        excp_req = 1'b0;
        excp_pc  = 32'hBFC00380;
        eret_req = 1'b0;
        eret_pc  = 32'h80001000;
        #3;
        chk("rst_stall", stall, 0);
        chk("rst_flush", flush, 0);
        chk("rst_new_pc", new_pc, 0);
        chk("rst_cnt", stall_cnt, 0);
        chk("rst_timeout", stall_timeout, 0);
        chk("rst_stall_total", stall_total, 0);
        chk("rst_flush_total", flush_total, 0);
        @(negedge clk);
        rst = 1'b0;
        step();

        // prefix stall and consecutive count
        stallreq = 6'b000100;
        #1;
        chk("pfx_stall0", stall, 6'b000111);
        chk("pfx_cnt0", stall_cnt, 0);
        for (int i = 1; i <= 3; i++) begin
            step();
            chk("pfx_stall", stall, 6'b000111);
            chk("pfx_cnt", stall_cnt, i);
        end
        stallreq = '0;
        step();
        chk("pfx_cnt_clr", stall_cnt, 0);
        chk("pfx_stall_clr", stall, 0);
        stallreq = 6'b100000;
        #1;
        chk("pfx_top", stall, 6'b111111);
        stallreq = 6'b000001;
        #1;
        chk("pfx_bot", stall, 6'b000001);
        stallreq = '0;
        step();

        // exception flush then two refill cycles
        excp_req = 1'b1;
        step();
        excp_req = 1'b0;
        chk("ex_flush", flush, 1);
        chk("ex_new_pc", new_pc, 32'hBFC00380);
        stallreq = 6'b000010;
        #1;
        chk("ex_stall_forced", stall, 0);
        stallreq = '0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("ex_after_flush", flush, 0);
        end

        // simultaneous exception and eret: one flush, eret dropped
        excp_req = 1'b1;
        eret_req = 1'b1;
        step();
        excp_req = 1'b0;
        eret_req = 1'b0;
        chk("both_flush", flush, 1);
        chk("both_new_pc", new_pc, 32'hBFC00380);
        for (int i = 0; i < 6; i++) begin
            step();
            chk("both_no_eret", flush, 0);
        end

        // eret during first refill cycle is serviced at end of refill
        excp_req = 1'b1;
        step();
        excp_req = 1'b0;
        chk("pend_flush1", flush, 1);
        step();
        chk("pend_refill1", flush, 0);
        eret_req = 1'b1;
        step();
        eret_req = 1'b0;
        chk("pend_refill2", flush, 0);
        chk("pend_pc_held", new_pc, 32'hBFC00380);
        step();
        chk("pend_flush2", flush, 1);
        chk("pend_new_pc", new_pc, 32'h80001000);
        step();
        chk("pend_no_double", flush, 0);
        step();
        chk("pend_refill_b", flush, 0);
        step();
        chk("pend_run", flush, 0);
`ifdef PIPE_CTRL_PERF_EN
        chk("perf_flush_total", flush_total, 4);
`endif

        // stuck-stall watchdog
        stallreq = 6'b001000;
        for (int i = 1; i <= 200; i++) begin
            step();
            if (i == 1 || i == 199 || i == 200) begin
                chk("to_cnt", stall_cnt, i);
                chk("to_flag", stall_timeout, (i == 200) ? 1 : 0);
            end
        end
        stallreq = '0;
        step();
        chk("to_cnt_clr", stall_cnt, 0);
        chk("to_sticky", stall_timeout, 1);
        step();
        chk("to_sticky2", stall_timeout, 1);

        // async reset mid-refill with an eret pending
        excp_req = 1'b1;
        step();
        excp_req = 1'b0;
        chk("ar_flush", flush, 1);
        step();
        eret_req = 1'b1;
        step();
        eret_req = 1'b0;
        stallreq = 6'b000100;
        step();
        #2;
        rst = 1'b1;
        stallreq = '0;
        #1;
        chk("ar_flush0", flush, 0);
        chk("ar_new_pc0", new_pc, 0);
        chk("ar_cnt0", stall_cnt, 0);
        chk("ar_timeout0", stall_timeout, 0);
        chk("ar_stall0", stall, 0);
        chk("ar_stall_total0", stall_total, 0);
        chk("ar_flush_total0", flush_total, 0);
        #2;
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("ar_no_flush", flush, 0);
        end
        chk("ar_new_pc_kept0", new_pc, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
